// File: rtl/grover_pkg.sv
// Shared types, sizes and helpers for the grover sweep controller.
package grover_pkg;

  localparam int N_STATES = 8;    // amplitude count, fixed by the grover core
  localparam int AMP_W    = 8;    // signed two's-complement amplitude width
  localparam int IDX_W    = 3;    // log2(N_STATES)
  localparam int TIMEOUT  = 255;  // WAIT cycles allowed before a run is aborted
  localparam int WAIT_W   = 8;    // wide enough to count to TIMEOUT-1
  localparam int CNT_W    = 4;    // pass/fail tally width

  typedef logic [AMP_W-1:0] amp_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam idx_t                LAST_IDX  = idx_t'(N_STATES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRST,
    LAUNCH,
    WAIT,
    SCAN,
    REPORT,
    DONE
  } state_t;

  // |a| as an unsigned AMP_W-bit value; the most negative code maps to 2^(AMP_W-1).
  function automatic amp_t abs_mag(input amp_t a);
    return a[AMP_W-1] ? amp_t'(~a + amp_t'(1)) : a;
  endfunction

  // Tally increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : cnt_t'(c + cnt_t'(1));
  endfunction

endpackage

// File: rtl/grover_argmax.sv
// Sequential arg-max over a latched set of amplitudes, one index per cycle.
// 'finished' is high during the cycle that examines the last index, so the
// result on 'idx' is final from the following cycle onward.
module grover_argmax
  import grover_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [N_STATES-1:0][AMP_W-1:0] amps_in,
  output idx_t                           idx,
  output logic                           finished
);

  logic [N_STATES-1:0][AMP_W-1:0] amp_q;
  idx_t                           k_q;
  idx_t                           best_idx_q;
  amp_t                           best_mag_q;
  logic                           active_q;
  amp_t                           cur_mag;

  assign cur_mag  = abs_mag(amp_q[k_q]);
  assign finished = active_q && (k_q == LAST_IDX);
  assign idx      = best_idx_q;

  // Snapshot of the core's outputs taken on the capture strobe.
  // NOTE: this data register has no reset; it is only consumed while active_q
  // is set, which is itself reset, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (load) amp_q <= amps_in;
  end

  // Scan control: one comparison per cycle, strictly-greater keeps the lowest index on ties.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q   <= 1'b0;
      k_q        <= '0;
      best_idx_q <= '0;
      best_mag_q <= '0;
    end else if (load) begin
      active_q   <= 1'b1;
      k_q        <= '0;
      best_idx_q <= '0;
      best_mag_q <= '0;
    end else if (active_q) begin
      if (cur_mag > best_mag_q) begin
        best_mag_q <= cur_mag;
        best_idx_q <= k_q;
      end
      if (finished) active_q <= 1'b0;
      else          k_q      <= k_q + idx_t'(1);
    end
  end

endmodule

// File: rtl/grover_sweep_ctrl.sv
// Drives the grover core through targets 0..7, measures each result by
// arg-max of |amplitude|, and keeps pass/fail tallies and the LED display.
module grover_sweep_ctrl
  import grover_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             g_rst,
  output logic             g_start,
  output logic [IDX_W-1:0] g_target,
  input  logic             g_done,
  input  logic [AMP_W-1:0] a0,
  input  logic [AMP_W-1:0] a1,
  input  logic [AMP_W-1:0] a2,
  input  logic [AMP_W-1:0] a3,
  input  logic [AMP_W-1:0] a4,
  input  logic [AMP_W-1:0] a5,
  input  logic [AMP_W-1:0] a6,
  input  logic [AMP_W-1:0] a7,
  output logic [IDX_W-1:0] meas_idx,
  output logic             meas_valid,
  output logic             match,
  output logic [3:0]       pass_cnt,
  output logic [3:0]       fail_cnt,
  output logic             timeout_err,
  output logic             busy,
  output logic             sweep_done,
  output logic [7:0]       led
);

  state_t              state_q, state_d;
  logic                grst_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                timed_out_q;
  logic                load;
  logic                scan_finished;
  idx_t                scan_idx;
  idx_t                report_idx;
  logic                report_match;
  logic [N_STATES-1:0][AMP_W-1:0] amps;

  assign amps = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign load = (state_q == WAIT) && g_done;

  // A timed-out run reports the complement of its target so it can never look like a hit.
  assign report_idx   = timed_out_q ? ~g_target : scan_idx;
  assign report_match = !timed_out_q && (scan_idx == g_target);

  grover_argmax u_argmax (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .amps_in  (amps),
    .idx      (scan_idx),
    .finished (scan_finished)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and core-facing strobes, decoded from the current state.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    g_rst      = 1'b0;
    g_start    = 1'b0;
    busy       = 1'b1;
    sweep_done = 1'b0;
    case (state_q)
      IDLE: begin
        g_rst = 1'b1;
        busy  = 1'b0;
        if (run) state_d = GRST;
      end
      DONE: begin
        g_rst      = 1'b1;
        busy       = 1'b0;
        sweep_done = 1'b1;
        if (run) state_d = GRST;
      end
      GRST: begin
        g_rst = 1'b1;
        if (grst_cnt_q) state_d = LAUNCH;
      end
      LAUNCH: begin
        g_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        g_start = 1'b1;
        if (g_done)                        state_d = SCAN;
        else if (wait_cnt_q == WAIT_LAST)  state_d = REPORT;
      end
      SCAN: begin
        if (scan_finished) state_d = REPORT;
      end
      REPORT: begin
        state_d = (g_target == LAST_IDX) ? DONE : GRST;
      end
      default: begin
        g_rst   = 1'b1;
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Run bookkeeping: reset-hold counter, WAIT timer, results, tallies and target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grst_cnt_q  <= 1'b0;
      wait_cnt_q  <= '0;
      timed_out_q <= 1'b0;
      g_target    <= '0;
      meas_idx    <= '0;
      meas_valid  <= 1'b0;
      match       <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
      led         <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (run) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
            g_target    <= '0;
          end
        end
        GRST: begin
          // Toggles 0 -> 1 -> 0, giving exactly two cycles and leaving it ready for the next run.
          grst_cnt_q <= ~grst_cnt_q;
        end
        LAUNCH: begin
          wait_cnt_q  <= '0;
          timed_out_q <= 1'b0;
        end
        WAIT: begin
          if (!g_done) begin
            if (wait_cnt_q == WAIT_LAST) begin
              timed_out_q <= 1'b1;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        REPORT: begin
          meas_valid <= 1'b1;
          meas_idx   <= report_idx;
          match      <= report_match;
          led        <= N_STATES'(1) << report_idx;
          if (report_match) pass_cnt <= sat_inc(pass_cnt);
          else              fail_cnt <= sat_inc(fail_cnt);
          if (g_target != LAST_IDX) g_target <= g_target + idx_t'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
